// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and an optional 2-entry skid.
// M is the head entry presented downstream; S catches one extra entry so that
// in_ready can be registered when SKID_EN=1. Flush bubbles the stage and Busy
// freezes it. A saturating bubble counter supports performance debug.
module pipe_stage_skid #(
   parameter int CTRL_W     = 16,
   parameter int DATA_W     = 128,
   parameter bit SKID_EN    = 1'b1,
   parameter bit CLEAR_DATA = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              Flush,
   input  logic              Busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_cnt,
   input  logic              bubble_clr
);

   logic              m_valid;
   logic [CTRL_W-1:0] m_ctrl;
   logic [DATA_W-1:0] m_data;
   logic              s_valid;
   logic [CTRL_W-1:0] s_ctrl;
   logic [DATA_W-1:0] s_data;
   logic              in_fire;
   logic              out_fire;

   // Handshake and output view; with the skid, in_ready never looks at out_ready.
   always_comb begin
      if (SKID_EN) begin
         in_ready = ~s_valid & ~Busy & ~Flush;
      end else begin
         in_ready = ~Busy & ~Flush & (~m_valid | out_ready);
      end
      out_valid = m_valid & ~Busy;
      out_ctrl  = m_valid ? m_ctrl : '0;
      out_data  = m_data;
      occupancy = 2'(m_valid) + 2'(s_valid);
      in_fire   = in_valid & in_ready;
      out_fire  = out_valid & out_ready;
   end

   // Stage state: flush beats busy, busy freezes, otherwise advance M/S in order.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         m_valid <= 1'b0;
         m_ctrl  <= '0;
         m_data  <= '0;
         s_valid <= 1'b0;
         s_ctrl  <= '0;
         s_data  <= '0;
      end else if (Flush) begin
         m_valid <= 1'b0;
         m_ctrl  <= '0;
         s_valid <= 1'b0;
         s_ctrl  <= '0;
         if (CLEAR_DATA) begin
            m_data <= '0;
            s_data <= '0;
         end
      end else if (!Busy) begin
         if (!m_valid) begin
            if (in_fire) begin
               m_valid <= 1'b1;
               m_ctrl  <= in_ctrl;
               m_data  <= in_data;
            end
         end else if (out_fire) begin
            if (s_valid) begin
               // in_ready is low while S is full, so nothing new arrives here
               m_ctrl  <= s_ctrl;
               m_data  <= s_data;
               s_valid <= 1'b0;
               s_ctrl  <= '0;
            end else if (in_fire) begin
               m_ctrl <= in_ctrl;
               m_data <= in_data;
            end else begin
               m_valid <= 1'b0;
               m_ctrl  <= '0;
            end
         end else if (in_fire && SKID_EN) begin
            s_valid <= 1'b1;
            s_ctrl  <= in_ctrl;
            s_data  <= in_data;
         end
      end
   end

   // Bubble counter: clear wins, then saturating increment on starved cycles.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         bubble_cnt <= '0;
      end else if (bubble_clr) begin
         bubble_cnt <= '0;
      end else if (out_ready && !out_valid && !(&bubble_cnt)) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule
